mac_engine: RTL and testbench
=============================

MAC_ENGINE -- requirements
Module: mac_engine

Interface
REQ-001 Parameter DATA_W, default 8: operand width in bits.
REQ-002 Parameter ACC_W, default 16: accumulator width; SHALL satisfy ACC_W >= 2*DATA_W, enforced by an elaboration-time check.
REQ-003 Parameter CNT_W, default 8: width of the operation counter.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  operand pair a/b is presented.
REQ-007 in_ready  out  1  block can accept an operand pair this cycle.
REQ-008 a, b  in  DATA_W each  operands.
REQ-009 signed_mode  in  1  1 = two's-complement operands and accumulator, 0 = unsigned; sampled with the operands.
REQ-010 clr  in  1  clear the accumulator and discard in-flight operations.
REQ-011 flush  in  1  request a drain of the pipeline followed by a done pulse.
REQ-012 acc_out  out  ACC_W  accumulator value.
REQ-013 out_valid  out  1  one-cycle pulse when acc_out has just absorbed an operation.
REQ-014 done  out  1  one-cycle pulse marking the end of a flush.
REQ-015 op_count  out  CNT_W  number of operations accumulated since the last clear or reset.
REQ-016 ovf  out  1  sticky overflow flag.

Function
REQ-017 An operation SHALL be accepted on any rising edge where in_valid and in_ready are both 1.
REQ-018 Pipeline: stage 1 registers a, b and signed_mode; stage 2 registers the 2*DATA_W product; stage 3 adds the product into acc_out.
REQ-019 An operation accepted at edge k SHALL update acc_out at edge k+2, and out_valid SHALL be 1 during the cycle that follows edge k+2.
REQ-020 The block SHALL sustain back-to-back acceptance, one operation per cycle, with no bubbles.
REQ-021 The product SHALL be sign-extended (signed_mode=1) or zero-extended (signed_mode=0) to ACC_W bits before the add.
REQ-022 Overflow is detected in the active mode: signed overflow of the ACC_W-bit sum, or unsigned carry-out.
REQ-023 ovf SHALL be set on any overflow and SHALL stay set until clr or rst.
REQ-024 op_count SHALL increment by 1 per accumulated operation and SHALL saturate at all-ones; it never wraps.
REQ-025 State machine RUN, DRAIN, DONE; RUN is the reset state.
REQ-026 in_ready SHALL be 1 in RUN and 0 in DRAIN and DONE.
REQ-027 RUN -> DRAIN on an edge with flush=1.
REQ-028 DRAIN -> DONE on the first edge at which no stage holds a valid operation.
REQ-029 DONE -> RUN after exactly one cycle; done SHALL be 1 only while the state is DONE.
REQ-030 In DONE, acc_out SHALL be the final sum of every operation accepted before the flush.
REQ-031 An operation accepted on the same edge that flush is seen SHALL be included in the drained result.
REQ-032 clr=1 at an edge SHALL zero acc_out, op_count and ovf, SHALL invalidate stages 2 and 3, and SHALL force the state to RUN.
REQ-033 An operation accepted on the same edge as clr SHALL be kept and becomes the first term of the new sum.
REQ-034 flush and clr asserted together: clr SHALL win, and no done pulse is produced.

Reset
REQ-035 On rst=1 at an edge: acc_out=0, op_count=0, ovf=0, out_valid=0, done=0, all pipeline valid bits=0, state=RUN.
REQ-036 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-037 rst asserted mid-operation SHALL discard all in-flight operations; no out_valid pulse for them.

Configuration
REQ-038 Macro MAC_SATURATE_EN, when defined, SHALL clamp the result on overflow:
- signed mode: clamp to +(2^(ACC_W-1))-1 or -2^(ACC_W-1);
- unsigned mode: clamp to 2^ACC_W-1;
- ovf is still set.
REQ-039 With MAC_SATURATE_EN undefined, the accumulator SHALL wrap modulo 2^ACC_W, and ovf is still set on overflow.

Verification
REQ-040 Defaults, unsigned; accept 3*4, 2*5, 1*10 on consecutive edges -> acc_out 12, 22, 32 on three consecutive out_valid pulses; op_count=3.
REQ-041 signed_mode=1; accept a=0xFD (-3), b=4 -> acc_out=0xFFF4 (-12); ovf=0.
REQ-042 Unsigned; accept 255*255 twice:
- without MAC_SATURATE_EN -> acc_out 65025, then 64514, with ovf=1;
- with MAC_SATURATE_EN -> acc_out 65025, then 65535, with ovf=1.
REQ-043 Accept 5*5, then assert flush on the following edge -> in_ready=0 during the drain, done pulses exactly once with acc_out=25, and in_ready returns to 1 the cycle after done.
REQ-044 Accept 7*7 at edge k and assert clr at edge k+1 -> acc_out=0, op_count=0, and no out_valid pulse for 7*7.
REQ-045 Accept 2*3 at edge k and assert rst at edge k+1 -> all outputs at reset values; in_ready=1 after rst deasserts; no stale out_valid pulse.

Source files
------------

// File: rtl/mac_engine.sv
// Pipelined multiply-accumulate engine with flush/drain handshake and sticky overflow.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_engine #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  input  logic              clr,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc_out,
  output logic              out_valid,
  output logic              done,
  output logic [CNT_W-1:0]  op_count,
  output logic              ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("mac_engine: ACC_W must be at least 2*DATA_W");
  end

  localparam logic [PROD_W-1:0] OPND_HI = ~PROD_W'({DATA_W{1'b1}});
  localparam logic [ACC_W-1:0]  PROD_HI = ~ACC_W'({PROD_W{1'b1}});
  localparam logic [ACC_W-1:0]  S_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]  S_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0]  U_MAX   = {ACC_W{1'b1}};

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic                v1, v2;
  logic                m1, m2;
  logic [DATA_W-1:0]   a1, b1;
  logic [PROD_W-1:0]   p2;
  logic                accept;

  // Ready only in RUN; reset blocks acceptance immediately, not one edge later
  assign in_ready = (state == RUN) && !rst;
  assign accept   = in_valid && in_ready;

  // Stage 2 multiply: extend operands to product width so one multiplier serves both modes
  logic [PROD_W-1:0] ax_c, bx_c, prod_c;
  always_comb begin
    ax_c   = PROD_W'(a1) | ((m1 && a1[DATA_W-1]) ? OPND_HI : '0);
    bx_c   = PROD_W'(b1) | ((m1 && b1[DATA_W-1]) ? OPND_HI : '0);
    prod_c = ax_c * bx_c;
  end

  // Stage 3 add with mode-dependent overflow detection
  logic [ACC_W-1:0] ext_c, acc_nxt_c;
  logic [ACC_W:0]   sum_c;
  logic             ovf_c;
  always_comb begin
    ext_c = ACC_W'(p2) | ((m2 && p2[PROD_W-1]) ? PROD_HI : '0);
    sum_c = {1'b0, acc_out} + {1'b0, ext_c};
    if (m2) begin
      ovf_c = (acc_out[ACC_W-1] == ext_c[ACC_W-1]) && (sum_c[ACC_W-1] != acc_out[ACC_W-1]);
    end else begin
      ovf_c = sum_c[ACC_W];
    end
`ifdef MAC_SATURATE_EN
    if (ovf_c) begin
      if (m2) begin
        acc_nxt_c = acc_out[ACC_W-1] ? S_MIN : S_MAX;
      end else begin
        acc_nxt_c = U_MAX;
      end
    end else begin
      acc_nxt_c = sum_c[ACC_W-1:0];
    end
`else
    acc_nxt_c = sum_c[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      v1        <= 1'b0;
      v2        <= 1'b0;
      m1        <= 1'b0;
      m2        <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      p2        <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      op_count  <= '0;
      ovf       <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= a;
        b1 <= b;
        m1 <= signed_mode;
      end
      v2        <= v1 && !clr;
      p2        <= prod_c;
      m2        <= m1;
      out_valid <= v2 && !clr;
      done      <= 1'b0;

      if (clr) begin
        // Stage 1 survives so an operation accepted now starts the new sum
        acc_out  <= '0;
        op_count <= '0;
        ovf      <= 1'b0;
        state    <= RUN;
      end else begin
        if (v2) begin
          acc_out <= acc_nxt_c;
          ovf     <= ovf | ovf_c;
          if (op_count != {CNT_W{1'b1}}) begin
            op_count <= op_count + CNT_W'(1);
          end
        end
        case (state)
          RUN: begin
            if (flush) state <= DRAIN;
          end
          DRAIN: begin
            if (!v1 && !v2) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE:    state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_engine.sv
// Self-checking bench for mac_engine: scoreboard of expected accumulator pulses plus flush/clr/reset scenarios.
module tb_mac_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_mode;
  logic        clr;
  logic        flush;
  logic [15:0] acc_out;
  logic        out_valid;
  logic        done;
  logic [7:0]  op_count;
  logic        ovf;

  typedef struct packed {
    logic [15:0] val;
    logic [31:0] cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         obs_q[$];
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  mac_engine dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .clr         (clr),
    .flush       (flush),
    .acc_out     (acc_out),
    .out_valid   (out_valid),
    .done        (done),
    .op_count    (op_count),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and record any out_valid pulse with its cycle stamp
  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (out_valid === 1'b1) obs_q.push_back({acc_out, 32'(cyc)});
  endtask

  // Operation driven now is accepted at the next edge and visible two edges later
  task automatic expect_acc(input logic [15:0] v);
    exp_q.push_back({v, 32'(cyc + 3)});
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_checks++; if (acc_out !== 16'd0) begin n_fail++; $display("FAIL reset_acc: got %0d want 0", acc_out); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", op_count); end
    n_checks++; if ({ovf, out_valid, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {ovf, out_valid, done}); end
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    obs_q.delete();
  endtask

  task automatic test_basic();
    ev_t o, e;
    in_valid = 1'b1;
    a = 8'd3; b = 8'd4;  expect_acc(16'd12); tick();
    a = 8'd2; b = 8'd5;  expect_acc(16'd22); tick();
    a = 8'd1; b = 8'd10; expect_acc(16'd32); tick();
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL basic_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL basic_acc: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    n_checks++; if (op_count !== 8'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", op_count); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_signed();
    ev_t o, e;
    do_clr();
    signed_mode = 1'b1; in_valid = 1'b1;
    a = 8'hFD; b = 8'd4; expect_acc(16'hFFF4); tick();
    in_valid = 1'b0; signed_mode = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL signed_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL signed_acc: got %h@%0d want %h@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL signed_ovf: got %b want 0", ovf); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow();
    ev_t o, e;
    do_clr();
    in_valid = 1'b1; a = 8'd255; b = 8'd255;
    expect_acc(16'd65025); tick();
`ifdef MAC_SATURATE_EN
    expect_acc(16'd65535); tick();
`else
    expect_acc(16'd64514); tick();
`endif
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL ovf_acc: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr_inflight();
    in_valid = 1'b1; a = 8'd7; b = 8'd7; tick();
    in_valid = 1'b0; clr = 1'b1; tick();
    clr = 1'b0;
    repeat (4) tick();
    n_checks++; if (acc_out !== 16'd0) begin n_fail++; $display("FAIL clr_acc: got %0d want 0", acc_out); end
    n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", op_count); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", ovf); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL clr_stale_pulse: got %0d pulses want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_clr_accept();
    ev_t o, e;
    in_valid = 1'b1; a = 8'd9; b = 8'd9; tick();
    a = 8'd2; b = 8'd2; clr = 1'b1; expect_acc(16'd4); tick();
    in_valid = 1'b0; clr = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL clracc_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL clracc_acc: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL clracc_count: got %0d want 1", op_count); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush();
    ev_t o, e;
    do_clr();
    in_valid = 1'b1; a = 8'd5; b = 8'd5; expect_acc(16'd25); tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_checks++; if (done !== (i == 2)) begin n_fail++; $display("FAIL flush_done[%0d]: got %b want %b", i, done, (i == 2)); end
      n_checks++; if (in_ready !== (i >= 3)) begin n_fail++; $display("FAIL flush_ready[%0d]: got %b want %b", i, in_ready, (i >= 3)); end
      if (i == 2) begin
        n_checks++; if (acc_out !== 16'd25) begin n_fail++; $display("FAIL flush_acc: got %0d want 25", acc_out); end
      end
      tick();
    end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL flush_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL flush_out: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_flush_clr();
    int dones;
    dones = 0;
    flush = 1'b1; clr = 1'b1; tick();
    flush = 1'b0; clr = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flushclr_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) dones++;
      tick();
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flushclr_done: got %0d pulses want 0", dones); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    ev_t o, e;
    int  sum;
    do_clr();
    sum = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom_range(0, 15));
      b = 8'($urandom_range(0, 15));
      sum = sum + int'(a) * int'(b);
      expect_acc(16'(sum));
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_pulses: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL b2b_acc: got %0d@%0d want %0d@%0d", o.val, o.cyc, e.val, e.cyc); end
    end
    n_checks++; if (op_count !== 8'd20) begin n_fail++; $display("FAIL b2b_count: got %0d want 20", op_count); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_count_sat();
    int mism;
    ev_t o, e;
    do_clr();
    mism = 0;
    in_valid = 1'b1; a = 8'd0; b = 8'd0;
    for (int i = 0; i < 260; i++) begin
      expect_acc(16'd0);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o !== e) mism++;
    end
    n_checks++; if (mism != 0 || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL sat_stream: got %0d mismatched/%0d leftover want 0/0", mism, obs_q.size() + exp_q.size()); end
    n_checks++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL sat_count: got %0d want 255", op_count); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_inflight();
    in_valid = 1'b1; a = 8'd2; b = 8'd3; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    n_checks++; if (acc_out !== 16'd0 || op_count !== 8'd0) begin n_fail++; $display("FAIL rstop_regs: got acc %0d cnt %0d want 0 0", acc_out, op_count); end
    n_checks++; if ({ovf, out_valid, done} !== 3'b000) begin n_fail++; $display("FAIL rstop_flags: got %b want 000", {ovf, out_valid, done}); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstop_ready: got %b want 1", in_ready); end
    repeat (4) tick();
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstop_stale_pulse: got %0d pulses want 0", obs_q.size()); end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    signed_mode = 1'b0; clr = 1'b0; flush = 1'b0;
    cyc = 0; n_checks = 0; n_fail = 0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_clr_inflight();
    test_clr_accept();
    test_flush();
    test_flush_clr();
    test_back_to_back();
    test_count_sat();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
